// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, parity modes and the parity helper.
// The transmitter uses this package now; a receiver can reuse it unchanged.
package uart_pkg;

  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_START = 3'd1;
  localparam logic [2:0] ENC_DATA  = 3'd2;
  localparam logic [2:0] ENC_PAR   = 3'd3;
  localparam logic [2:0] ENC_STOP  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ENC_IDLE,
    ST_START = ENC_START,
    ST_DATA  = ENC_DATA,
    ST_PAR   = ENC_PAR,
    ST_STOP  = ENC_STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // The word is zero-extended to 9 bits, so the extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: down-counter reloaded by restart, tick high at terminal count.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_baud_gen: CLKS_PER_BIT must be at least 2");
  end

  logic [CW-1:0] bit_cnt_q, bit_cnt_d;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (restart) begin
      bit_cnt_d = RELOAD;
    end else if (bit_cnt_q != '0) begin
      bit_cnt_d = bit_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign tick = (bit_cnt_q == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter with valid/ready intake, optional parity and
// one or two stop bits. txd, tx_busy and tx_done are registered.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
    $error("uart_tx_cfg: illegal parameter combination");
  end

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 restart;
  logic                 tick;
  logic                 accept;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  assign accept = tx_valid && (state_q == ST_IDLE);

  // txd_d always carries the level of the bit being entered, so the line
  // changes on the same edge that starts the bit.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_idx_d = bit_idx_q;
    par_d     = par_q;
    txd_d     = txd_q;
    done_d    = 1'b0;
    restart   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (accept) begin
          sh_d    = tx_data;
          par_d   = parity_bit(9'(tx_data), PARITY);
          txd_d   = 1'b0;
          restart = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          restart   = 1'b1;
          txd_d     = sh_q[0];
          sh_d      = sh_q >> 1;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          restart = 1'b1;
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
            if (PARITY != PAR_NONE) begin
              txd_d   = par_q;
              state_d = ST_PAR;
            end else begin
              txd_d   = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            txd_d     = sh_q[0];
            sh_d      = sh_q >> 1;
          end
        end
      end
      ST_PAR: begin
        if (tick) begin
          restart   = 1'b1;
          txd_d     = 1'b1;
          bit_idx_d = '0;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_idx_q == LAST_STOP) begin
            txd_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            restart   = 1'b1;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      bit_idx_q <= '0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_idx_q <= bit_idx_d;
      par_q     <= par_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx_ready = (state_q == ST_IDLE);
  assign txd      = txd_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule
